// File: rtl/fram_ctrl.sv
// Host-side controller for a 64Kx16 F-RAM with an asynchronous SRAM-style pin interface.
// Runs one single-word read or write per request, with cycle-counted access and precharge.
module fram_ctrl #(
    parameter int unsigned T_ACC = 7,
    parameter int unsigned T_PC  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    output logic        ready,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic [1:0]  be,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic [15:0] fram_addr,
    output logic [15:0] fram_dq_o,
    output logic        fram_dq_oe,
    input  logic [15:0] fram_dq_i,
    output logic        fram_ce_n,
    output logic        fram_we_n,
    output logic        fram_oe_n,
    output logic        fram_ub_n,
    output logic        fram_lb_n
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(T_ACC - 1);
    // HOLD is the first of the T_PC ce_n-high cycles, so PRECHARGE runs T_PC-1 cycles
    localparam logic [CNT_W-1:0] PC_LOAD  = (T_PC >= 2) ? CNT_W'(T_PC - 2) : '0;

    if (T_ACC < 2 || T_ACC > 255) begin : g_bad_t_acc
        $error("fram_ctrl: T_ACC must be in 2..255");
    end
    if (T_PC == 0 || T_PC > 255) begin : g_bad_t_pc
        $error("fram_ctrl: T_PC must be in 1..255");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_HOLD,
        S_PRECHARGE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic [1:0]       be_q, be_d;
    logic [15:0]      addr_q, addr_d;
    logic [15:0]      dq_o_q, dq_o_d;
    logic             dq_oe_q, dq_oe_d;
    logic             ce_n_q, ce_n_d;
    logic             we_n_q, we_n_d;
    logic             oe_n_q, oe_n_d;
    logic             ub_n_q, ub_n_d;
    logic             lb_n_q, lb_n_d;
    logic             rd_valid_q, rd_valid_d;
    logic [15:0]      rd_data_q, rd_data_d;

    // Next-state and next-pin logic: pin registers are loaded with the values of the state being entered
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        be_d       = be_q;
        addr_d     = addr_q;
        dq_o_d     = dq_o_q;
        dq_oe_d    = dq_oe_q;
        ce_n_d     = ce_n_q;
        we_n_d     = we_n_q;
        oe_n_d     = oe_n_q;
        ub_n_d     = ub_n_q;
        lb_n_d     = lb_n_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_SETUP;
                    wr_d    = wr;
                    be_d    = be;
                    addr_d  = addr;
                    if (wr) begin
                        dq_o_d  = wdata;
                        dq_oe_d = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = ACC_LOAD;
                ce_n_d  = 1'b0;
                if (wr_q) begin
                    we_n_d = 1'b0;
                    ub_n_d = ~be_q[1];
                    lb_n_d = ~be_q[0];
                end else begin
                    oe_n_d = 1'b0;
                    ub_n_d = 1'b0;
                    lb_n_d = 1'b0;
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    ce_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    ub_n_d  = 1'b1;
                    lb_n_d  = 1'b1;
                    if (!wr_q) begin
                        rd_data_d  = fram_dq_i;
                        rd_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                cnt_d   = PC_LOAD;
                dq_oe_d = 1'b0;
                state_d = (T_PC == 1) ? S_IDLE : S_PRECHARGE;
            end
            S_PRECHARGE: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            be_q       <= 2'b00;
            addr_q     <= '0;
            dq_o_q     <= '0;
            dq_oe_q    <= 1'b0;
            ce_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            ub_n_q     <= 1'b1;
            lb_n_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            dq_o_q     <= dq_o_d;
            dq_oe_q    <= dq_oe_d;
            ce_n_q     <= ce_n_d;
            we_n_q     <= we_n_d;
            oe_n_q     <= oe_n_d;
            ub_n_q     <= ub_n_d;
            lb_n_q     <= lb_n_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign ready      = (state_q == S_IDLE);
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign fram_addr  = addr_q;
    assign fram_dq_o  = dq_o_q;
    assign fram_dq_oe = dq_oe_q;
    assign fram_ce_n  = ce_n_q;
    assign fram_we_n  = we_n_q;
    assign fram_oe_n  = oe_n_q;
    assign fram_ub_n  = ub_n_q;
    assign fram_lb_n  = lb_n_q;

endmodule

// File: tb/tb_fram_ctrl.sv
// Bench for fram_ctrl: a pin-level F-RAM device model, a word-level reference memory and timing monitors.
module tb_fram_ctrl;

    localparam int T_ACC = 7;
    localparam int T_PC  = 4;
    localparam int E_ACC = 2;
    localparam int E_PC  = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, wr, ready, rd_valid;
    logic [15:0] addr, wdata, rd_data;
    logic [1:0]  be;
    logic [15:0] fram_addr, fram_dq_o, fram_dq_i;
    logic        fram_dq_oe, fram_ce_n, fram_we_n, fram_oe_n, fram_ub_n, fram_lb_n;

    logic        e_req, e_wr, e_ready, e_rd_valid;
    logic [15:0] e_addr, e_wdata, e_rd_data;
    logic [1:0]  e_be;
    logic [15:0] e_fram_addr, e_fram_dq_o, e_fram_dq_i;
    logic        e_dq_oe, e_ce_n, e_we_n, e_oe_n, e_ub_n, e_lb_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fram_ctrl #(.T_ACC(T_ACC), .T_PC(T_PC)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ready(ready), .wr(wr), .addr(addr),
        .wdata(wdata), .be(be), .rd_valid(rd_valid), .rd_data(rd_data),
        .fram_addr(fram_addr), .fram_dq_o(fram_dq_o), .fram_dq_oe(fram_dq_oe),
        .fram_dq_i(fram_dq_i), .fram_ce_n(fram_ce_n), .fram_we_n(fram_we_n),
        .fram_oe_n(fram_oe_n), .fram_ub_n(fram_ub_n), .fram_lb_n(fram_lb_n)
    );

    fram_ctrl #(.T_ACC(E_ACC), .T_PC(E_PC)) u_dut_edge (
        .clk(clk), .rst_n(rst_n), .req(e_req), .ready(e_ready), .wr(e_wr), .addr(e_addr),
        .wdata(e_wdata), .be(e_be), .rd_valid(e_rd_valid), .rd_data(e_rd_data),
        .fram_addr(e_fram_addr), .fram_dq_o(e_fram_dq_o), .fram_dq_oe(e_dq_oe),
        .fram_dq_i(e_fram_dq_i), .fram_ce_n(e_ce_n), .fram_we_n(e_we_n),
        .fram_oe_n(e_oe_n), .fram_ub_n(e_ub_n), .fram_lb_n(e_lb_n)
    );

    // Power-up contents of every word before it is first written
    function automatic logic [15:0] pwr_up(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h1F2E;
    endfunction

    // Pin-level device: byte-masked writes while CE and WE are low, data driven while CE and OE are low
    logic [15:0] dev_mem [0:65535];
    bit          dev_valid [0:65535];
    logic [15:0] dev_cur;

    assign dev_cur     = dev_valid[fram_addr] ? dev_mem[fram_addr] : pwr_up(fram_addr);
    assign fram_dq_i   = (!fram_ce_n && !fram_oe_n) ? dev_cur : 16'hDEAD;
    assign e_fram_dq_i = (!e_ce_n && !e_oe_n) ? (e_fram_addr ^ 16'h5A5A) : 16'hDEAD;

    always @(posedge clk) begin
        if (!fram_ce_n && !fram_we_n && fram_dq_oe) begin
            dev_mem[fram_addr]   <= {fram_ub_n ? dev_cur[15:8] : fram_dq_o[15:8],
                                     fram_lb_n ? dev_cur[7:0]  : fram_dq_o[7:0]};
            dev_valid[fram_addr] <= 1'b1;
        end
    end

    // Word-level reference memory
    logic [15:0] ref_mem [int unsigned];

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pwr_up(a);
    endfunction

    task automatic ref_wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] b);
        logic [15:0] old;
        old = ref_rd(a);
        ref_mem[int'(a)] = {b[1] ? d[15:8] : old[15:8], b[0] ? d[7:0] : old[7:0]};
    endtask

    // Continuous pin monitor: CE pulse width, CE gap, control exclusivity, address stability
    bit          mon_en = 1'b0;
    int          lo_run, hi_run, ce_pulses;
    bit          had_pulse, prev_ready;
    logic [15:0] prev_addr;

    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            lo_run = 0; hi_run = 0; had_pulse = 0; prev_ready = 1'b1; prev_addr = fram_addr;
        end else begin
            if (!fram_ce_n) begin
                if (lo_run == 0 && had_pulse) begin
                    checks++;
                    if (hi_run < T_PC + 1) begin
                        errors++; $display("FAIL ce_gap got %0d need >= %0d", hi_run, T_PC + 1);
                    end
                end
                lo_run++; hi_run = 0;
            end else begin
                if (lo_run != 0) begin
                    checks++; ce_pulses++; had_pulse = 1'b1;
                    if (lo_run != T_ACC) begin
                        errors++; $display("FAIL ce_width got %0d need %0d", lo_run, T_ACC);
                    end
                end
                lo_run = 0; hi_run++;
            end
            checks++;
            if (!fram_we_n && !fram_oe_n) begin
                errors++; $display("FAIL we_oe_overlap we_n=%b oe_n=%b", fram_we_n, fram_oe_n);
            end
            checks++;
            if (fram_dq_oe && !fram_oe_n) begin
                errors++; $display("FAIL dq_oe_while_oe dq_oe=%b oe_n=%b", fram_dq_oe, fram_oe_n);
            end
            checks++;
            if (fram_addr !== prev_addr && !(prev_ready && fram_ce_n)) begin
                errors++; $display("FAIL addr_change got %h was %h outside setup", fram_addr, prev_addr);
            end
            prev_addr  = fram_addr;
            prev_ready = ready;
        end
    end

    // Per-transaction measurements, k counts cycles after the accept edge (k=1 is the first busy cycle)
    logic [15:0] t_rdata;
    int t_lat, t_rdy, t_ce, t_oe, t_we, t_doe, t_abad;

    task automatic do_txn(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [1:0] b);
        bit done;
        t_lat = 0; t_rdy = 0; t_ce = 0; t_oe = 0; t_we = 0; t_doe = 0; t_abad = 0; t_rdata = 'x;
        @(negedge clk);
        req = 1'b1; wr = w; addr = a; wdata = d; be = b;
        for (int i = 0; i < 50 && !ready; i++) @(negedge clk);
        done = 1'b0;
        for (int k = 1; k <= 60 && !done; k++) begin
            @(negedge clk);
            if (k == 1) req = 1'b0;
            if (ready) begin
                done = 1'b1;
            end else begin
                t_rdy++;
                if (!fram_ce_n) t_ce++;
                if (!fram_oe_n) t_oe++;
                if (!fram_we_n) t_we++;
                if (fram_dq_oe && !w) t_doe++;
                if (fram_addr !== a) t_abad++;
            end
            if (rd_valid) begin
                t_lat = k; t_rdata = rd_data;
            end
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL txn_timeout addr=%h ready never returned", a);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0; be = 2'b00;
        e_req = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0; e_be = 2'b00;
        #12;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b need 1", ready); end
        checks++; if ({fram_ce_n, fram_we_n, fram_oe_n, fram_ub_n, fram_lb_n} !== 5'b11111) begin
            errors++; $display("FAIL rst_ctrl got %b need 11111", {fram_ce_n, fram_we_n, fram_oe_n, fram_ub_n, fram_lb_n});
        end
        checks++; if (fram_dq_oe !== 1'b0) begin errors++; $display("FAIL rst_dq_oe got %b need 0", fram_dq_oe); end
        checks++; if (fram_addr !== 16'h0) begin errors++; $display("FAIL rst_addr got %h need 0000", fram_addr); end
        checks++; if (fram_dq_o !== 16'h0) begin errors++; $display("FAIL rst_dq_o got %h need 0000", fram_dq_o); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got %b need 0", rd_valid); end
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL rst_rd_data got %h need 0000", rd_data); end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ready !== 1'b1 || fram_ce_n !== 1'b1) begin
            errors++; $display("FAIL post_rst_idle ready=%b ce_n=%b need 1 1", ready, fram_ce_n);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_write_read;
        do_txn(1'b1, 16'h00A5, 16'h1234, 2'b11);
        ref_wr(16'h00A5, 16'h1234, 2'b11);
        checks++; if (t_we !== T_ACC || t_oe !== 0) begin
            errors++; $display("FAIL wr_pins we_low=%0d oe_low=%0d need %0d 0", t_we, t_oe, T_ACC);
        end
        checks++; if (t_rdy !== 1 + T_ACC + T_PC) begin
            errors++; $display("FAIL wr_busy got %0d need %0d", t_rdy, 1 + T_ACC + T_PC);
        end
        checks++; if (t_lat !== 0) begin errors++; $display("FAIL wr_rd_valid got pulse at %0d need none", t_lat); end
        do_txn(1'b0, 16'h00A5, 16'h0000, 2'b00);
        checks++; if (t_rdata !== 16'h1234) begin errors++; $display("FAIL rd_data got %h need 1234", t_rdata); end
        checks++; if (t_lat !== T_ACC + 2) begin errors++; $display("FAIL rd_latency got %0d need %0d", t_lat, T_ACC + 2); end
        checks++; if (t_rdy !== 1 + T_ACC + T_PC) begin
            errors++; $display("FAIL rd_busy got %0d need %0d", t_rdy, 1 + T_ACC + T_PC);
        end
        checks++; if (t_oe !== T_ACC || t_ce !== T_ACC || t_we !== 0 || t_doe !== 0) begin
            errors++; $display("FAIL rd_pins oe=%0d ce=%0d we=%0d doe=%0d need %0d %0d 0 0", t_oe, t_ce, t_we, t_doe, T_ACC, T_ACC);
        end
        checks++; if (t_abad !== 0) begin errors++; $display("FAIL rd_addr_hold got %0d bad cycles need 0", t_abad); end
    endtask

    task automatic test_byte_write;
        logic [1:0]  bes [3] = '{2'b01, 2'b10, 2'b00};
        logic [15:0] exp [3] = '{16'h12CD, 16'hABCD, 16'hABCD};
        int p0;
        for (int i = 0; i < 3; i++) begin
            p0 = ce_pulses;
            do_txn(1'b1, 16'h00A5, 16'hABCD, bes[i]);
            ref_wr(16'h00A5, 16'hABCD, bes[i]);
            checks++; if (ce_pulses - p0 !== 1 || t_ce !== T_ACC) begin
                errors++; $display("FAIL be%b_ce pulses=%0d width=%0d need 1 %0d", bes[i], ce_pulses - p0, t_ce, T_ACC);
            end
            do_txn(1'b0, 16'h00A5, 16'h0000, 2'b11);
            checks++; if (t_rdata !== exp[i] || t_rdata !== ref_rd(16'h00A5)) begin
                errors++; $display("FAIL be%b_data got %h need %h", bes[i], t_rdata, exp[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [15:0] pool [8];
        logic [15:0] a, d;
        logic [1:0]  b;
        logic        w;
        for (int i = 0; i < 8; i++) pool[i] = 16'($urandom);
        for (int n = 0; n < 24; n++) begin
            a = pool[$urandom_range(0, 7)];
            w = 1'($urandom_range(0, 1));
            d = 16'($urandom);
            b = 2'($urandom);
            do_txn(w, a, d, b);
            if (w) begin
                ref_wr(a, d, b);
                checks++; if (t_lat !== 0 || t_we !== T_ACC || t_rdy !== 1 + T_ACC + T_PC) begin
                    errors++; $display("FAIL rnd_wr lat=%0d we=%0d busy=%0d need 0 %0d %0d", t_lat, t_we, t_rdy, T_ACC, 1 + T_ACC + T_PC);
                end
            end else begin
                checks++; if (t_rdata !== ref_rd(a) || t_lat !== T_ACC + 2) begin
                    errors++; $display("FAIL rnd_rd addr=%h got %h lat %0d need %h lat %0d", a, t_rdata, t_lat, ref_rd(a), T_ACC + 2);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int acc, runs, good, run, rv, p0;
        acc = 0; runs = 0; good = 0; run = 0; rv = 0; p0 = ce_pulses;
        @(negedge clk);
        req = 1'b1; wr = 1'b0; addr = 16'h00A5; be = 2'b11;
        for (int k = 0; k < 80; k++) begin
            if (req && ready) acc++;
            @(negedge clk);
            if (acc == 3 && req) req = 1'b0;
            if (!ready) begin
                run++;
            end else if (run != 0) begin
                runs++;
                if (run == 1 + T_ACC + T_PC) good++;
                run = 0;
            end
            if (rd_valid) begin
                rv++;
                checks++; if (rd_data !== ref_rd(16'h00A5)) begin
                    errors++; $display("FAIL b2b_data got %h need %h", rd_data, ref_rd(16'h00A5));
                end
            end
        end
        checks++; if (acc !== 3 || runs !== 3 || good !== 3) begin
            errors++; $display("FAIL b2b_busy accepts=%0d runs=%0d exact=%0d need 3 3 3", acc, runs, good);
        end
        checks++; if (rv !== 3 || ce_pulses - p0 !== 3) begin
            errors++; $display("FAIL b2b_pulses rd_valid=%0d ce=%0d need 3 3", rv, ce_pulses - p0);
        end
    endtask

    task automatic test_reset_mid_write;
        mon_en = 1'b0;
        @(negedge clk);
        req = 1'b1; wr = 1'b1; addr = 16'h0300; wdata = 16'h5555; be = 2'b11;
        for (int i = 0; i < 50 && !ready; i++) @(negedge clk);
        @(negedge clk); req = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (fram_ce_n !== 1'b0 || fram_we_n !== 1'b0 || fram_dq_oe !== 1'b1) begin
            errors++; $display("FAIL mid_wr_active ce_n=%b we_n=%b oe=%b need 0 0 1", fram_ce_n, fram_we_n, fram_dq_oe);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (fram_ce_n !== 1'b1 || fram_we_n !== 1'b1 || fram_dq_oe !== 1'b0 || ready !== 1'b1) begin
            errors++; $display("FAIL async_rst ce_n=%b we_n=%b oe=%b ready=%b need 1 1 0 1", fram_ce_n, fram_we_n, fram_dq_oe, ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        do_txn(1'b0, 16'h00A5, 16'h0000, 2'b11);
        checks++; if (t_rdata !== ref_rd(16'h00A5) || t_lat !== T_ACC + 2) begin
            errors++; $display("FAIL post_rst_rd got %h lat %0d need %h lat %0d", t_rdata, t_lat, ref_rd(16'h00A5), T_ACC + 2);
        end
    endtask

    task automatic test_edge_params;
        logic [15:0] a, got;
        int rdy, ce, lat;
        bit done;
        for (int n = 0; n < 3; n++) begin
            a = 16'($urandom); rdy = 0; ce = 0; lat = 0; got = 'x; done = 1'b0;
            @(negedge clk);
            e_req = 1'b1; e_addr = a;
            for (int i = 0; i < 20 && !e_ready; i++) @(negedge clk);
            for (int k = 1; k <= 20 && !done; k++) begin
                @(negedge clk);
                if (k == 1) e_req = 1'b0;
                if (e_ready) done = 1'b1;
                else begin
                    rdy++;
                    if (!e_ce_n) ce++;
                end
                if (e_rd_valid) begin lat = k; got = e_rd_data; end
            end
            checks++; if (rdy !== 1 + E_ACC + E_PC || ce !== E_ACC || lat !== E_ACC + 2) begin
                errors++; $display("FAIL edge_timing busy=%0d ce=%0d lat=%0d need %0d %0d %0d", rdy, ce, lat, 1 + E_ACC + E_PC, E_ACC, E_ACC + 2);
            end
            checks++; if (got !== (a ^ 16'h5A5A)) begin
                errors++; $display("FAIL edge_data got %h need %h", got, a ^ 16'h5A5A);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_write();
        test_back_to_back();
        test_random();
        test_reset_mid_write();
        test_edge_params();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
